// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave backed by a word-addressed SRAM array
module axi_sram_slave #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        aclk,
  input  logic        reset,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Shared storage; deliberately not reset so contents survive a bus reset.
  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [7:0]  r_cnt;
  logic [31:0] r_next;

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [7:0]  w_cnt;
  logic        w_dec;
  logic [31:0] w_next;
  logic        w_fire;

  // Lock/cache/prot carry no meaning for a plain memory; wid is redundant in AXI3 ordering here.
  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  function automatic logic in_range(input logic [31:0] a);
    return a[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-3:0] word_idx(input logic [31:0] a);
    return a[ADDR_W-1:2];
  endfunction

  // Address of the following beat; sizes above one word behave as one word,
  // the reserved burst type behaves as INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [2:0]  sh;
    logic [31:0] incr;
    logic [31:0] mask;
    sh   = (size > 3'd2) ? 3'd2 : size;
    incr = 32'd1 << sh;
    mask = (({24'd0, len} + 32'd1) << sh) - 32'd1;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + incr) & mask);
      default: next_addr = a + incr;
    endcase
  endfunction

  assign r_next  = next_addr(r_addr, r_len, r_size, r_burst);
  assign w_next  = next_addr(w_addr, w_len, w_size, w_burst);

  // Handshake outputs are pure decodes of the state registers.
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_BURST);
  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign w_fire  = wready && wvalid;

  // Read FSM: the beat's data is fetched one cycle ahead, at the AR or previous R handshake.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      rid     <= 4'd0;
      rdata   <= 32'd0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'b00;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_state <= R_BURST;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= 8'd0;
            rlast   <= (arlen == 8'd0);
            if (in_range(araddr)) begin
              rdata <= mem[word_idx(araddr)];
              rresp <= RESP_OKAY;
            end else begin
              rdata <= 32'd0;
              rresp <= RESP_DECERR;
            end
          end
        end
        R_BURST: begin
          if (rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= r_cnt + 8'd1;
              rlast  <= ((r_cnt + 8'd1) == r_len);
              if (in_range(r_next)) begin
                rdata <= mem[word_idx(r_next)];
                rresp <= RESP_OKAY;
              end else begin
                rdata <= 32'd0;
                rresp <= RESP_DECERR;
              end
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: tracks beat address, beat count and decode errors, then holds the response.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_addr  <= 32'd0;
      w_len   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'b00;
      w_cnt   <= 8'd0;
      w_dec   <= 1'b0;
      bid     <= 4'd0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_state <= W_DATA;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= 8'd0;
            w_dec   <= 1'b0;
            bid     <= awid;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_addr <= w_next;
            if (w_cnt != 8'hff) w_cnt <= w_cnt + 8'd1;
            if (!in_range(w_addr)) w_dec <= 1'b1;
            if (wlast) begin
              w_state <= W_RESP;
              // w_cnt counts earlier beats, so a well-formed burst ends with w_cnt == awlen.
              if (w_dec || !in_range(w_addr)) bresp <= RESP_DECERR;
              else if (w_cnt != w_len)        bresp <= RESP_SLVERR;
              else                            bresp <= RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane array write; a same-cycle read of the word still sees the old value.
  always_ff @(posedge aclk) begin
    if (w_fire && in_range(w_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized scoreboard bench for axi_sram_slave
module tb_axi_sram_slave;

  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave dut (
    .aclk(aclk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [31:0] mdl [int];
  logic [31:0] wd_buf [256];
  logic [3:0]  ws_buf [256];
  int          checks = 0;
  int          errors = 0;
  int          r_hs = 0;
  int          rr_mode = 0;   // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic inr(input logic [31:0] a);
    return a[31:16] == BASE[31:16];
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[15:2]);
  endfunction

  // Beat i address from the burst rules, using byte offsets inside the wrap block.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] sz, input logic [1:0] bu, input int i);
    int n;
    int blk;
    logic [31:0] lower;
    n = 1 << ((sz > 3'd2) ? 2 : int'(sz));
    case (bu)
      2'b00: return start;
      2'b10: begin
        blk   = (int'(len) + 1) * n;
        lower = start - (start % blk);
        return lower + ((start - lower) + i * n) % blk;
      end
      default: return start + i * n;
    endcase
  endfunction

  // rready / bready drivers
  initial forever begin
    @(posedge aclk); #1;
    rready = (rr_mode == 0) ? ($urandom % 4 != 0) : (rr_mode == 2);
    bready = ($urandom % 4 != 0);
  end

  // Monitor: compares every R/B handshake against the scoreboard and checks R stability.
  initial begin
    logic        prev_stall;
    logic [38:0] prev;
    rexp_t re;
    bexp_t be;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge aclk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("r_hold_valid", 64'(rvalid), 64'd1);
          check("r_hold_payload", 64'({rid, rdata, rresp, rlast}), 64'(prev));
        end
        if (rvalid && rready) begin
          r_hs++;
          if (r_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
          else begin
            re = r_q.pop_front();
            check("rid", 64'(rid), 64'(re.id));
            check("rdata", 64'(rdata), 64'(re.data));
            check("rresp", 64'(rresp), 64'(re.resp));
            check("rlast", 64'(rlast), 64'(re.last));
          end
        end
        prev_stall = rvalid && !rready;
        prev = {rid, rdata, rresp, rlast};
        if (bvalid && bready) begin
          if (b_q.size() == 0) check("b_unexpected", 64'd1, 64'd0);
          else begin
            be = b_q.pop_front();
            check("bid", 64'(bid), 64'(be.id));
            check("bresp", 64'(bresp), 64'(be.resp));
          end
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge aclk);
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    rexp_t e;
    logic [31:0] ba;
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, len, sz, bu, i);
      e.id = id;
      if (inr(ba)) begin e.data = mdl[widx(ba)]; e.resp = 2'b00; end
      else begin e.data = 32'd0; e.resp = 2'b11; end
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    @(posedge aclk); #1;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (arready) break;
      t++;
      if (t > 200) begin check("ar_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input int nbeats);
    bexp_t e;
    logic [31:0] ba;
    logic dec;
    int t;
    dec = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      ba = beat_addr(a, len, sz, bu, i);
      if (!inr(ba)) dec = 1'b1;
      else begin
        for (int b = 0; b < 4; b++)
          if (ws_buf[i][b]) mdl[widx(ba)][b*8 +: 8] = wd_buf[i][b*8 +: 8];
      end
    end
    e.id = id;
    e.resp = dec ? 2'b11 : (nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    b_q.push_back(e);
    @(posedge aclk); #1;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (awready) break;
      t++;
      if (t > 200) begin check("aw_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom % 4 == 0) begin @(posedge aclk); #1; end
      wdata = wd_buf[i]; wstrb = ws_buf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge aclk);
        if (wready) break;
        t++;
        if (t > 200) begin check("w_timeout", 64'd0, 64'd1); break; end
      end
      @(posedge aclk); #1;
      wvalid = 1'b0; wlast = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    if (t >= 3000) check("drain_timeout", 64'(r_q.size() + b_q.size()), 64'd0);
    repeat (2) @(posedge aclk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          nb;
    int          t;
    rexp_t       re;
    bexp_t       be;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rpayload", 64'({rid, rdata, rresp, rlast}), 64'd0);
    check("rst_bpayload", 64'({bid, bresp}), 64'd0);
    @(negedge aclk);
    reset = 1'b0;

    // Fill words 0..63 so every later read of the region has known contents.
    for (int i = 0; i < 64; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
    do_write(4'd1, BASE, 8'd63, 3'd2, 2'b01, 64);
    drain();

    // INCR write and read-back at 0x100.
    for (int i = 0; i < 4; i++) begin wd_buf[i] = 32'h1111_1111 * (i + 1); ws_buf[i] = 4'hf; end
    do_write(4'd3, BASE + 32'h100, 8'd3, 3'd2, 2'b01, 4);
    drain();
    do_read(4'd4, BASE + 32'h100, 8'd3, 3'd2, 2'b01);
    drain();

    // Byte strobes.
    wd_buf[0] = 32'haabb_ccdd; ws_buf[0] = 4'hf;
    do_write(4'd5, BASE + 32'h200, 8'd0, 3'd2, 2'b01, 1);
    wd_buf[0] = 32'h1122_3344; ws_buf[0] = 4'b0101;
    do_write(4'd6, BASE + 32'h200, 8'd0, 3'd2, 2'b01, 1);
    drain();
    do_read(4'd7, BASE + 32'h200, 8'd0, 3'd2, 2'b01);
    drain();

    // WRAP read starting mid-block.
    do_read(4'd8, BASE + 32'h108, 8'd3, 3'd2, 2'b10);
    drain();

    // Backpressure: hold rready low for 3 cycles in the middle of a burst.
    rr_mode = 2;
    t = r_hs;
    do_read(4'd9, BASE, 8'd7, 3'd2, 2'b01);
    while (r_hs < t + 3) @(negedge aclk);
    rr_mode = 1;
    repeat (3) @(posedge aclk);
    rr_mode = 0;
    drain();

    // Out-of-range read and short write burst.
    do_read(4'd10, 32'h2000_0000, 8'd1, 3'd2, 2'b01);
    drain();
    for (int i = 0; i < 2; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
    do_write(4'd11, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 2);
    drain();

    // Overlapping read and write bursts on disjoint words.
    for (int i = 0; i < 8; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hf; end
    fork
      do_write(4'd12, BASE + 32'h80, 8'd7, 3'd2, 2'b01, 8);
      do_read(4'd13, BASE, 8'd7, 3'd2, 2'b01);
    join
    drain();

    // Same-word collision: AR and W handshake on the same edge -> old data.
    old_v = mdl[10];
    new_v = ~old_v ^ 32'h5a5a_0f0f;
    re.id = 4'd5; re.data = old_v; re.resp = 2'b00; re.last = 1'b1;
    r_q.push_back(re);
    be.id = 4'd6; be.resp = 2'b00;
    b_q.push_back(be);
    @(posedge aclk); #1;
    awid = 4'd6; awaddr = BASE + 32'd40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (awready) break;
      t++;
      if (t > 200) begin check("aw_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    arid = 4'd5; araddr = BASE + 32'd40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    wdata = new_v; wstrb = 4'hf; wlast = 1'b1; wvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge aclk);
      if (arready && wready) break;
      t++;
      if (t > 200) begin check("collide_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge aclk); #1;
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    mdl[10] = new_v;
    drain();
    do_read(4'd14, BASE + 32'd40, 8'd0, 3'd2, 2'b01);
    drain();

    // Randomized sequential traffic.
    for (int k = 0; k < 60; k++) begin
      sz = 3'($urandom % 4);
      bu = 2'($urandom % 4);
      if (bu == 2'b10) len = 8'((2 << ($urandom % 4)) - 1);
      else len = 8'($urandom % 16);
      nb = 1 << ((sz > 3'd2) ? 2 : int'(sz));
      a = 32'($urandom % 193) & ~32'(nb - 1);
      a = (($urandom % 10) == 0) ? (32'h2000_0000 + a) : (BASE + a);
      if ($urandom % 2 == 0) begin
        nb = int'(len) + 1;
        if ($urandom % 6 == 0) nb = $urandom_range(1, int'(len) + 1);
        for (int i = 0; i < nb; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'($urandom); end
        do_write(4'($urandom), a, len, sz, bu, nb);
      end else begin
        do_read(4'($urandom), a, len, sz, bu);
      end
      drain();
    end

    // Reset mid-read-burst, then a normal burst after release.
    rr_mode = 2;
    t = r_hs;
    do_read(4'd2, BASE, 8'd15, 3'd2, 2'b01);
    while (r_hs < t + 3) @(negedge aclk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_arready", 64'(arready), 64'd1);
    check("midrst_awready", 64'(awready), 64'd1);
    r_q.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    reset = 1'b0;
    rr_mode = 0;
    do_read(4'd15, BASE + 32'h20, 8'd7, 3'd2, 2'b01);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
